// File: rtl/dft_pkg.sv
// Shared definitions for the dft_bins streaming DFT engine.
//   - PI, FSM state encoding
//   - width helpers, half-away-from-zero rounding, twiddle and Hann generators
//     (evaluated while the tables are elaborated)
package dft_pkg;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int sw, input int tw, input int n);
    return sw + tw + $clog2(n);
  endfunction

  function automatic int round_haz(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  // cos/sin(2*pi*i/n) scaled to Q1.(tw-1), full scale 2^(tw-1)-1
  function automatic int tw_val(input int i, input int n, input int tw, input bit is_sin);
    real a, amp;
    a   = 2.0 * PI * real'(i) / real'(n);
    amp = real'((1 << (tw - 1)) - 1);
    return round_haz((is_sin ? $sin(a) : $cos(a)) * amp);
  endfunction

  // Hann coefficient, unsigned Q0.16; w = 1.0 at n = N/2 saturates to 0xFFFF
  function automatic int hann_val(input int i, input int n);
    int w;
    w = round_haz(0.5 * (1.0 - $cos(2.0 * PI * real'(i) / real'(n))) * 65536.0);
    return (w > 65535) ? 65535 : w;
  endfunction
endpackage

// File: rtl/dft_twiddle_rom.sv
// Twiddle ROM for one DFT bin: cos/sin tables for phases 0..N-1.
//   clk, rst_n : clock, async active-low reset
//   ph         : phase index
//   tw_cos     : registered cos[ph], signed Q1.(TW-1)
//   tw_sin     : registered sin[ph], signed Q1.(TW-1)
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int N  = 64,
  parameter int TW = 16,
  localparam int LW = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LW-1:0]        ph,
  output logic signed [TW-1:0] tw_cos,
  output logic signed [TW-1:0] tw_sin
);

  logic signed [TW-1:0] cos_tab [N];
  logic signed [TW-1:0] sin_tab [N];

  for (genvar i = 0; i < N; i++) begin : g_tab
    assign cos_tab[i] = TW'(tw_val(i, N, TW, 1'b0));
    assign sin_tab[i] = TW'(tw_val(i, N, TW, 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_cos <= '0;
      tw_sin <= '0;
    end else begin
      tw_cos <= cos_tab[ph];
      tw_sin <= sin_tab[ph];
    end
  end

endmodule

// File: rtl/dft_bins.sv
// Streaming multi-bin DFT: accumulates a frame of N real samples into
// NUM_BINS consecutive bins k = kbase..kbase+NUM_BINS-1 (mod N), then
// streams the complex results out one bin per handshake.
//   clk, rst_n          : clock, async active-low reset
//   cfg_kbase           : first bin, captured with the first sample of a frame
//   s_data/valid/ready  : sample input stream
//   m_re/m_im/m_bin     : result of bin m_bin
//   m_last              : final bin of the frame
//   m_valid/m_ready     : result output stream
// Build option: define DFT_HANN_EN to apply a Hann window to the input
// (one extra pipeline stage, flush becomes 3 cycles).
module dft_bins
  import dft_pkg::*;
#(
  parameter int N        = 64,
  parameter int NUM_BINS = 4,
  parameter int SW       = 16,
  parameter int TW       = 16,
  localparam int LW      = idx_w(N),
  localparam int AW      = acc_w(SW, TW, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LW-1:0]        cfg_kbase,
  input  logic signed [SW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [AW-1:0] m_re,
  output logic signed [AW-1:0] m_im,
  output logic [LW-1:0]        m_bin,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int BW = idx_w(NUM_BINS);
  localparam int PW = SW + TW;

  state_t        state, state_nx;
  logic          rdy;
  logic [LW-1:0] cnt, kbase_q, k_eff;
  logic [1:0]    fcnt;
  logic [BW-1:0] idx;
  logic          accept, last_smp, fire, done;

  logic signed [SW-1:0] x_q, x_a;
  logic [NUM_BINS-1:0][AW-1:0] acc_re_a, acc_im_a;

  assign s_ready  = rdy;
  assign accept   = s_valid && rdy;
  assign last_smp = accept && (cnt == LW'(N - 1));
  assign fire     = m_valid && m_ready;
  assign done     = fire && m_last;
  // kbase is not yet registered while sample 0 is being accepted
  assign k_eff    = (cnt == '0) ? cfg_kbase : kbase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_q <= '0;
    else if (accept) x_q <= s_data;
  end

`ifdef DFT_HANN_EN
  localparam int STAGES = 1;
  logic [15:0]            hann_tab [N];
  logic [15:0]            w_q;
  logic signed [SW+16:0]  xw, xw_rnd;
  logic signed [SW-1:0]   x_h;

  for (genvar i = 0; i < N; i++) begin : g_hann
    assign hann_tab[i] = 16'(hann_val(i, N));
  end

  assign xw     = (SW+17)'(x_q) * (SW+17)'($signed({1'b0, w_q}));
  // half-away-from-zero: negative products round with 0x7FFF, floor shift does the rest
  assign xw_rnd = xw + (xw[SW+16] ? (SW+17)'(32767) : (SW+17)'(32768));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      x_h <= '0;
    end else begin
      if (accept) w_q <= hann_tab[cnt];
      x_h <= SW'(xw_rnd >>> 16);
    end
  end
  assign x_a = x_h;
`else
  localparam int STAGES = 0;
  assign x_a = x_q;
`endif

  localparam int FLUSH_CYC = STAGES + 2;

  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (last_smp) state_nx = FLUSH;
      FLUSH:   if (fcnt == 2'(FLUSH_CYC - 1)) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      rdy     <= 1'b0;
      cnt     <= '0;
      kbase_q <= '0;
      fcnt    <= '0;
      idx     <= '0;
    end else begin
      state <= state_nx;
      rdy   <= (state_nx == ACCUM);
      if (accept) begin
        cnt <= last_smp ? '0 : cnt + LW'(1);
        if (cnt == '0) kbase_q <= cfg_kbase;
      end
      fcnt <= (state == FLUSH) ? fcnt + 2'd1 : 2'd0;
      if (fire) idx <= m_last ? '0 : idx + BW'(1);
    end
  end

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
    logic [LW-1:0]        ph;
    logic signed [TW-1:0] c, s, c_a, s_a;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [AW-1:0] acc_re, acc_im;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= '0;
      else if (accept) ph <= last_smp ? '0 : ph + k_eff + LW'(b);
    end

    dft_twiddle_rom #(.N(N), .TW(TW)) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .ph     (ph),
      .tw_cos (c),
      .tw_sin (s)
    );

`ifdef DFT_HANN_EN
    // keep twiddles aligned with the windowed sample
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_a <= '0;
        s_a <= '0;
      end else begin
        c_a <= c;
        s_a <= s;
      end
    end
`else
    assign c_a = c;
    assign s_a = s;
`endif

    assign p_re = PW'(x_a) * PW'(c_a);
    assign p_im = PW'(x_a) * PW'(s_a);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (done) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (vld_pipe[STAGES]) begin
        acc_re <= acc_re + AW'(p_re);
        acc_im <= acc_im - AW'(p_im);
      end
    end

    assign acc_re_a[b] = acc_re;
    assign acc_im_a[b] = acc_im;
  end

  assign m_valid = (state == DRAIN);
  assign m_last  = m_valid && (idx == BW'(NUM_BINS - 1));
  assign m_re    = m_valid ? acc_re_a[idx] : '0;
  assign m_im    = m_valid ? acc_im_a[idx] : '0;
  assign m_bin   = m_valid ? kbase_q + LW'(idx) : '0;

endmodule
